// File: rtl/spi_master_sequencer.sv
// spi_master_sequencer: SPI mode 0 burst controller driving an external sclk generator.
// Define SPI_LSB_FIRST_EN to shift and assemble bytes LSB first.
module spi_master_sequencer #(
    parameter int CS_SETUP_CYCLES = 4,
    parameter int CS_HOLD_CYCLES  = 4,
    parameter int COUNT_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_bytes,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    output logic               busy,
    output logic               done,
    output logic               gen_reset,
    input  logic               high_t,
    input  logic               low_t,
    output logic               cs_n,
    output logic               mosi,
    input  logic               miso
);
    localparam int MAX_CYC = CS_SETUP_CYCLES > CS_HOLD_CYCLES ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, HOLD} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         bit_cnt;
    logic [COUNT_W-1:0] remaining;
    logic [6:0]         shift_tx;
    logic [6:0]         shift_rx;
    logic [7:0]         rx_next;
    logic [6:0]         tx_load;
    logic [6:0]         tx_shift;
    logic               tx_first;
    logic               tx_bit;

    // shift_tx holds only the bits not yet driven; shift_rx only the bits already received
`ifdef SPI_LSB_FIRST_EN
    assign rx_next  = {miso, shift_rx};
    assign tx_load  = tx_data[7:1];
    assign tx_first = tx_data[0];
    assign tx_bit   = shift_tx[0];
    assign tx_shift = {1'b0, shift_tx[6:1]};
`else
    assign rx_next  = {shift_rx, miso};
    assign tx_load  = tx_data[6:0];
    assign tx_first = tx_data[7];
    assign tx_bit   = shift_tx[6];
    assign tx_shift = {shift_tx[5:0], 1'b0};
`endif

    assign tx_ready = state == LOAD;
    assign busy     = state != IDLE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            gen_reset <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            shift_tx  <= '0;
            shift_rx  <= '0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (start && num_bytes != '0) begin
                    remaining <= num_bytes;
                    cs_n      <= 1'b0;
                    cnt       <= '0;
                    state     <= SETUP;
                end
                SETUP: if (cnt == CW'(CS_SETUP_CYCLES - 1)) begin
                    cnt   <= '0;
                    state <= LOAD;
                end else cnt <= cnt + 1'b1;
                LOAD: if (tx_valid) begin
                    shift_tx  <= tx_load;
                    mosi      <= tx_first;
                    bit_cnt   <= '0;
                    gen_reset <= 1'b0;
                    state     <= XFER;
                end
                XFER: if (high_t) begin
                    shift_rx <= rx_next[6:0];
`ifdef SPI_LSB_FIRST_EN
                    shift_rx <= rx_next[7:1];
`endif
                    if (bit_cnt == 3'd7) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                    end
                end else if (low_t) begin
                    if (bit_cnt != 3'd7) begin
                        bit_cnt  <= bit_cnt + 1'b1;
                        shift_tx <= tx_shift;
                        mosi     <= tx_bit;
                    end else begin
                        remaining <= remaining - 1'b1;
                        gen_reset <= 1'b1;
                        cnt       <= '0;
                        state     <= remaining == COUNT_W'(1) ? HOLD : LOAD;
                    end
                end
                HOLD: if (cnt == CW'(CS_HOLD_CYCLES - 1)) begin
                    cs_n  <= 1'b1;
                    mosi  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_sequencer.sv
// tb_spi_master_sequencer: directed bursts against a behavioural sclk generator with mosi looped to miso.
module tb_spi_master_sequencer;
    localparam int H = 2;

    logic       clock = 0, reset = 1, start = 0, tx_valid = 0;
    logic [7:0] num_bytes = 0, tx_data = 0;
    logic [7:0] rx_data;
    logic       miso, tx_ready, rx_valid, busy, done, gen_reset, cs_n, mosi, high_t, low_t;
    logic       sclk = 0;
    int         gc = 0;

    spi_master_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .num_bytes(num_bytes),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .gen_reset(gen_reset), .high_t(high_t), .low_t(low_t),
        .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 clock = ~clock;
    assign miso   = mosi;
    assign high_t = !gen_reset && gc == H - 1;
    assign low_t  = !gen_reset && gc == 2 * H - 1;

    always @(posedge clock) begin
        if (gen_reset !== 1'b0) begin
            gc   <= 0;
            sclk <= 0;
        end else begin
            gc <= gc == 2 * H - 1 ? 0 : gc + 1;
            if (high_t) sclk <= 1;
            else if (low_t) sclk <= 0;
        end
    end

    int         cyc = 0, rises = 0, dones = 0, viol = 0, cs_fall = 0, cs_rise = 0, last_fall = 0;
    logic       sclk_q = 0, cs_q = 1;
    logic [7:0] rx_log[$];
    bit         mosi_log[$];
    int         rise_cyc[$];

    always @(negedge clock) begin
        cyc++;
        if (sclk && !sclk_q) begin
            rises++;
            mosi_log.push_back(mosi);
            rise_cyc.push_back(cyc);
            if (cs_n) viol++;
        end
        if (!sclk && sclk_q) last_fall = cyc;
        if (tx_ready && (sclk || cs_n)) viol++;
        if (!cs_n && cs_q) cs_fall = cyc;
        if (cs_n && !cs_q) cs_rise = cyc;
        if (rx_valid) rx_log.push_back(rx_data);
        if (done) dones++;
        sclk_q = sclk;
        cs_q   = cs_n;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bit exp_bit(input logic [7:0] b, input int i);
`ifdef SPI_LSB_FIRST_EN
        return b[i];
`else
        return b[7-i];
`endif
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!tx_ready && t < 200) begin
            step();
            t++;
        end
        chk("tx_ready_wait", tx_ready, 1);
    endtask

    task automatic run_burst(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input int gap, input bit restart);
        int         r0 = rises, x0 = rx_log.size(), d0 = dones, m0 = mosi_log.size(), v0 = viol;
        int         t = 0, bad = 0, setup = 0;
        logic [7:0] bs[2];
        bs[0] = b0;
        bs[1] = b1;
        num_bytes = 8'(n);
        start = 1;
        step();
        start = 0;
        for (int k = 0; k < n; k++) begin
            wait_ready();
            if (k == 1) repeat (gap) step();
            tx_data  = bs[k];
            tx_valid = 1;
            step();
            tx_valid = 0;
            // a second start mid-byte must not extend the burst
            if (restart && k == 0) begin
                repeat (6) step();
                num_bytes = 8'd3;
                start = 1;
                step();
                start = 0;
            end
        end
        while (dones == d0 && t < 500) begin
            step();
            t++;
        end
        repeat (3) step();
        chk("sclk_rises", rises - r0, 8 * n);
        chk("rx_count", rx_log.size() - x0, n);
        for (int k = 0; k < n; k++)
            chk("rx_byte", rx_log.size() > x0 + k ? int'(rx_log[x0 + k]) : -1, int'(bs[k]));
        chk("done_count", dones - d0, 1);
        for (int i = 0; i < 8 * n; i++)
            if (mosi_log.size() <= m0 + i || mosi_log[m0 + i] != exp_bit(bs[i / 8], i % 8)) bad++;
        chk("mosi_bits", bad, 0);
        if (rise_cyc.size() > r0) setup = rise_cyc[r0] - cs_fall;
        chk("cs_setup_ok", int'(setup >= 4), 1);
        chk("cs_hold", cs_rise - last_fall, 4);
        chk("framing_viol", viol - v0, 0);
        chk("idle_after", {busy, cs_n}, 2'b01);
    endtask

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        int         gap;
    } vec_t;

    vec_t vt[5];

    initial begin
        int r0, x0, d0, t, bad;
        vt[0] = '{1, 8'hA5, 8'h00, 0};
        vt[1] = '{2, 8'h3C, 8'hC3, 20};
        vt[2] = '{1, 8'h01, 8'h00, 0};
        vt[3] = '{2, 8'hFF, 8'h00, 3};
        vt[4] = '{2, 8'h80, 8'h7E, 0};

        repeat (3) step();
        reset = 0;
        step();
        chk("rst_cs_n", cs_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_gen_reset", gen_reset, 1);
        chk("rst_flags", {rx_valid, done, busy, tx_ready}, 0);
        chk("rst_rx_data", rx_data, 0);

        foreach (vt[i]) run_burst(vt[i].n, vt[i].b0, vt[i].b1, vt[i].gap, 0);

        // zero-length start is dropped without any visible effect
        d0 = dones;
        bad = 0;
        num_bytes = 0;
        start = 1;
        step();
        start = 0;
        repeat (50) begin
            if (busy || !cs_n || !gen_reset || done) bad++;
            step();
        end
        chk("zero_len_ignored", bad, 0);
        chk("zero_len_no_done", dones - d0, 0);

        run_burst(1, 8'h5A, 8'h00, 0, 1);

        // abort after three rises, then a clean burst
        r0 = rises;
        x0 = rx_log.size();
        d0 = dones;
        num_bytes = 1;
        start = 1;
        step();
        start = 0;
        wait_ready();
        tx_data  = 8'h66;
        tx_valid = 1;
        step();
        tx_valid = 0;
        t = 0;
        while (rises < r0 + 3 && t < 200) begin
            step();
            t++;
        end
        chk("abort_rises", rises - r0, 3);
        reset = 1;
        step();
        chk("abort_state", {cs_n, gen_reset, busy}, 3'b110);
        reset = 0;
        repeat (5) step();
        chk("abort_no_rx", rx_log.size() - x0, 0);
        chk("abort_no_done", dones - d0, 0);
        run_burst(1, 8'h81, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
